// File: rtl/c7bbiu_rd_mux.sv
// c7bbiu_rd_mux: round-robin arbiter of single-beat read requesters onto one AXI AR channel
// with ID-based R routing; define C7BBIU_RD_CANCEL_EN to build per-port response cancellation.
module c7bbiu_rd_mux #(
  parameter int NPORT    = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int IDW      = 4,
  parameter int MAX_OUTS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      req_val,
  input  logic [NPORT*AW-1:0]   req_addr,
  output logic [NPORT-1:0]      req_ack,
  input  logic [NPORT-1:0]      req_cancel,
  output logic [NPORT-1:0]      rsp_val,
  output logic [DW-1:0]         rsp_data,
  output logic [NPORT-1:0]      rsp_err,
  input  logic                  ext_biu_ar_ready,
  output logic                  biu_ext_ar_valid,
  output logic [IDW-1:0]        biu_ext_ar_id,
  output logic [AW-1:0]         biu_ext_ar_addr,
  output logic [7:0]            biu_ext_ar_len,
  output logic [2:0]            biu_ext_ar_size,
  output logic [1:0]            biu_ext_ar_burst,
  output logic                  biu_ext_ar_lock,
  output logic [3:0]            biu_ext_ar_cache,
  output logic [2:0]            biu_ext_ar_prot,
  output logic                  biu_ext_r_ready,
  input  logic                  ext_biu_r_valid,
  input  logic [IDW-1:0]        ext_biu_r_id,
  input  logic [DW-1:0]         ext_biu_r_data,
  input  logic                  ext_biu_r_last,
  input  logic [1:0]            ext_biu_r_resp
);
  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0][CW-1:0] out_cnt_q, out_cnt_d;
  logic [PW-1:0]            rr_ptr_q;
  logic                     ar_valid_q;
  logic [AW-1:0]            ar_addr_q;
  logic [IDW-1:0]           ar_id_q;
  logic                     r_ready_q;

  logic                     slot_free_s;
  logic                     gnt_any_s;
  logic [PW-1:0]            gnt_idx_s;
  logic [AW-1:0]            gnt_addr_s;
  logic [NPORT-1:0]         ack_s;
  logic [NPORT-1:0]         ret_s;
  logic [NPORT-1:0]         rsp_val_s;
  logic                     take_s;
  int                       dist_s;
  int                       best_d_s;

  // AR slot can take a new request when empty or being drained this cycle
  assign slot_free_s = ~ar_valid_q | ext_biu_ar_ready;

  // Round-robin pick: smallest distance from pointer+1 among eligible ports
  always_comb begin
    gnt_any_s  = 1'b0;
    gnt_idx_s  = '0;
    gnt_addr_s = '0;
    best_d_s   = NPORT;
    dist_s     = 0;
    take_s     = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      dist_s     = (p + NPORT - 1 - int'(rr_ptr_q)) % NPORT;
      take_s     = req_val[p] && (out_cnt_q[p] < CW'(MAX_OUTS)) && (dist_s < best_d_s);
      gnt_any_s  = gnt_any_s | take_s;
      gnt_idx_s  = take_s ? PW'(p) : gnt_idx_s;
      gnt_addr_s = take_s ? req_addr[p*AW +: AW] : gnt_addr_s;
      best_d_s   = take_s ? dist_s : best_d_s;
    end
  end

  // Per-port grant pulse, response retirement and outstanding count update
  always_comb begin
    ack_s     = '0;
    ret_s     = '0;
    out_cnt_d = out_cnt_q;
    for (int p = 0; p < NPORT; p++) begin
      ack_s[p]     = gnt_any_s & slot_free_s & (gnt_idx_s == PW'(p));
      ret_s[p]     = ext_biu_r_valid & ext_biu_r_last & (ext_biu_r_id == IDW'(p)) &
                     (out_cnt_q[p] != '0);
      out_cnt_d[p] = out_cnt_q[p] + CW'(ack_s[p]) - CW'(ret_s[p]);
    end
  end

`ifdef C7BBIU_RD_CANCEL_EN
  logic [NPORT-1:0][CW-1:0] drop_cnt_q, drop_cnt_d;
  logic                     unused_s;

  // Cancel snapshots the end-of-cycle outstanding count; dropped responses consume it
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    rsp_val_s  = '0;
    for (int p = 0; p < NPORT; p++) begin
      rsp_val_s[p] = ret_s[p] & (drop_cnt_q[p] == '0);
      if (req_cancel[p]) begin
        drop_cnt_d[p] = out_cnt_d[p];
      end else if (ret_s[p] && (drop_cnt_q[p] != '0)) begin
        drop_cnt_d[p] = drop_cnt_q[p] - CW'(1'b1);
      end else begin
        drop_cnt_d[p] = drop_cnt_q[p];
      end
    end
  end

  // Drop counter state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign unused_s = ext_biu_r_resp[0];
`else
  logic unused_s;

  assign rsp_val_s = ret_s;
  assign unused_s  = ^{ext_biu_r_resp[0], req_cancel};
`endif

  // AR register, round-robin pointer, outstanding counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      rr_ptr_q   <= '0;
      out_cnt_q  <= '0;
      r_ready_q  <= 1'b0;
    end else begin
      r_ready_q <= 1'b1;
      out_cnt_q <= out_cnt_d;
      if (gnt_any_s && slot_free_s) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= gnt_addr_s;
        ar_id_q    <= IDW'(gnt_idx_s);
        rr_ptr_q   <= gnt_idx_s;
      end else if (ext_biu_ar_ready) begin
        ar_valid_q <= 1'b0;
      end
    end
  end

  assign req_ack          = ack_s;
  assign rsp_val          = rsp_val_s;
  assign rsp_err          = rsp_val_s & {NPORT{ext_biu_r_resp[1]}};
  assign rsp_data         = ext_biu_r_data;
  assign biu_ext_ar_valid = ar_valid_q;
  assign biu_ext_ar_id    = ar_id_q;
  assign biu_ext_ar_addr  = ar_addr_q;
  assign biu_ext_ar_len   = 8'd0;
  assign biu_ext_ar_size  = 3'b010;
  assign biu_ext_ar_burst = 2'b01;
  assign biu_ext_ar_lock  = 1'b0;
  assign biu_ext_ar_cache = 4'd0;
  assign biu_ext_ar_prot  = 3'd0;
  assign biu_ext_r_ready  = r_ready_q;
endmodule

// File: tb/tb_c7bbiu_rd_mux.sv
// Scoreboard bench for c7bbiu_rd_mux: expected AR and R-routing results are queued when
// stimulus is driven and compared when the design presents them.
module tb_c7bbiu_rd_mux;
  localparam int NPORT = 2, AW = 32, DW = 32, IDW = 4, MAX_OUTS = 4;
`ifdef C7BBIU_RD_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic [NPORT-1:0] req_val, req_ack, req_cancel, rsp_val, rsp_err;
  logic [NPORT*AW-1:0] req_addr;
  logic [DW-1:0] rsp_data;
  logic ext_biu_ar_ready, biu_ext_ar_valid, biu_ext_ar_lock, biu_ext_r_ready;
  logic [IDW-1:0] biu_ext_ar_id, ext_biu_r_id;
  logic [AW-1:0] biu_ext_ar_addr;
  logic [7:0] biu_ext_ar_len;
  logic [2:0] biu_ext_ar_size, biu_ext_ar_prot;
  logic [1:0] biu_ext_ar_burst, ext_biu_r_resp;
  logic [3:0] biu_ext_ar_cache;
  logic ext_biu_r_valid, ext_biu_r_last;
  logic [DW-1:0] ext_biu_r_data;

  typedef struct { logic [IDW-1:0] id; logic [AW-1:0] addr; } ar_t;
  typedef struct { logic [NPORT-1:0] val; logic [DW-1:0] data; logic [NPORT-1:0] err; } rsp_t;
  ar_t  ar_q[$];
  rsp_t rsp_q[$];
  int total = 0;
  int bad = 0;

  c7bbiu_rd_mux #(.NPORT(NPORT), .AW(AW), .DW(DW), .IDW(IDW), .MAX_OUTS(MAX_OUTS)) dut (
    .clk(clk), .resetn(resetn), .req_val(req_val), .req_addr(req_addr), .req_ack(req_ack),
    .req_cancel(req_cancel), .rsp_val(rsp_val), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ext_biu_ar_ready(ext_biu_ar_ready), .biu_ext_ar_valid(biu_ext_ar_valid),
    .biu_ext_ar_id(biu_ext_ar_id), .biu_ext_ar_addr(biu_ext_ar_addr),
    .biu_ext_ar_len(biu_ext_ar_len), .biu_ext_ar_size(biu_ext_ar_size),
    .biu_ext_ar_burst(biu_ext_ar_burst), .biu_ext_ar_lock(biu_ext_ar_lock),
    .biu_ext_ar_cache(biu_ext_ar_cache), .biu_ext_ar_prot(biu_ext_ar_prot),
    .biu_ext_r_ready(biu_ext_r_ready), .ext_biu_r_valid(ext_biu_r_valid),
    .ext_biu_r_id(ext_biu_r_id), .ext_biu_r_data(ext_biu_r_data),
    .ext_biu_r_last(ext_biu_r_last), .ext_biu_r_resp(ext_biu_r_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    req_val = '0; req_cancel = '0;
    ext_biu_r_valid = 1'b0; ext_biu_r_id = '0; ext_biu_r_data = '0;
    ext_biu_r_last = 1'b0; ext_biu_r_resp = 2'b00;
  endtask

  task automatic do_reset();
    resetn = 1'b0; idle(); step(); step(); resetn = 1'b1;
  endtask

  // Drive one R-channel cycle and queue the routing result it must produce
  task automatic drive_r(input logic v, input logic [IDW-1:0] id, input logic [DW-1:0] data,
                         input logic [1:0] resp, input logic last, input logic [NPORT-1:0] exp_val);
    rsp_t e;
    ext_biu_r_valid = v; ext_biu_r_id = id; ext_biu_r_data = data;
    ext_biu_r_resp = resp; ext_biu_r_last = last;
    e.val = exp_val; e.data = data; e.err = resp[1] ? exp_val : '0;
    rsp_q.push_back(e);
  endtask

  task automatic push_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr);
    ar_t a;
    a.id = id; a.addr = addr;
    ar_q.push_back(a);
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle(); ext_biu_ar_ready = 1'b0; req_addr = '0;
    step(); step(); #1;
    total++;
    if ({biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr} !== '0) begin
      bad++; $display("FAIL reset_ar: valid=%b id=%0d addr=%h want 0", biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr);
    end
    total++;
    if ({req_ack, rsp_val, rsp_err} !== '0) begin
      bad++; $display("FAIL reset_out: ack=%b val=%b err=%b want 0", req_ack, rsp_val, rsp_err);
    end
    total++;
    if (biu_ext_r_ready !== 1'b0) begin
      bad++; $display("FAIL reset_rready: got %b want 0", biu_ext_r_ready);
    end
    resetn = 1'b1; step(); #1;
    total++;
    if (biu_ext_r_ready !== 1'b1) begin
      bad++; $display("FAIL rready_after: got %b want 1", biu_ext_r_ready);
    end
    total++;
    if ({biu_ext_ar_len, biu_ext_ar_size, biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot}
        !== {8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0}) begin
      bad++; $display("FAIL ar_const: len=%h size=%b burst=%b want 0/010/01", biu_ext_ar_len, biu_ext_ar_size, biu_ext_ar_burst);
    end
    step();
  endtask

  task automatic test_single_read();
    ar_t a; rsp_t e;
    do_reset(); ext_biu_ar_ready = 1'b1;
    req_val = 2'b01; req_addr = {32'h0, 32'h0000_1000}; #1;
    total++;
    if (req_ack !== 2'b01) begin bad++; $display("FAIL single_ack: got %b want 01", req_ack); end
    push_ar(4'd0, 32'h0000_1000);
    step(); req_val = 2'b00; #1;
    a = ar_q.pop_front(); total++;
    if (biu_ext_ar_valid !== 1'b1 || biu_ext_ar_id !== a.id || biu_ext_ar_addr !== a.addr) begin
      bad++; $display("FAIL single_ar: valid=%b id=%0d addr=%h want id=%0d addr=%h", biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, a.id, a.addr);
    end
    step(); #1;
    total++;
    if (biu_ext_ar_valid !== 1'b0) begin bad++; $display("FAIL single_ar_drop: valid=%b want 0", biu_ext_ar_valid); end
    drive_r(1'b1, 4'd0, 32'hDEAD_BEEF, 2'b00, 1'b1, 2'b01); #1;
    e = rsp_q.pop_front(); total++;
    if (rsp_val !== e.val || rsp_err !== e.err || (e.val != '0 && rsp_data !== e.data)) begin
      bad++; $display("FAIL single_rsp: val=%b err=%b data=%h want val=%b err=%b data=%h", rsp_val, rsp_err, rsp_data, e.val, e.err, e.data);
    end
    step(); idle();
  endtask

  task automatic test_round_robin();
    ar_t a; rsp_t e; logic [NPORT-1:0] exp_ack;
    do_reset(); ext_biu_ar_ready = 1'b1;
    req_addr = {32'h2000_0004, 32'h1000_0000}; req_val = 2'b11;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req_val = 2'b00;
      #1;
      if (i > 0) begin
        a = ar_q.pop_front(); total++;
        if (biu_ext_ar_valid !== 1'b1 || biu_ext_ar_id !== a.id || biu_ext_ar_addr !== a.addr) begin
          bad++; $display("FAIL rr_ar%0d: valid=%b id=%0d addr=%h want id=%0d addr=%h", i, biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, a.id, a.addr);
        end
      end
      exp_ack = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
      total++;
      if (req_ack !== exp_ack) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", i, req_ack, exp_ack); end
      if (i < 4) push_ar((i % 2 == 0) ? 4'd1 : 4'd0, (i % 2 == 0) ? 32'h2000_0004 : 32'h1000_0000);
      step();
    end
    for (int j = 0; j < 4; j++) begin
      drive_r(1'b1, IDW'(j % 2), 32'hA000_0000 + DW'(j), 2'b00, 1'b1, (j % 2 == 0) ? 2'b01 : 2'b10); #1;
      e = rsp_q.pop_front(); total++;
      if (rsp_val !== e.val || rsp_err !== e.err || (e.val != '0 && rsp_data !== e.data)) begin
        bad++; $display("FAIL rr_rsp%0d: val=%b err=%b data=%h want val=%b err=%b data=%h", j, rsp_val, rsp_err, rsp_data, e.val, e.err, e.data);
      end
      step();
    end
    idle();
  endtask

  task automatic test_backpressure();
    ar_t a; rsp_t e;
    logic [1:0] ack_tab [9] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    logic       rdy_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] drain_id [3] = '{4'd1, 4'd0, 4'd1};
    do_reset(); req_addr = {32'h0000_4000, 32'h0000_3000};
    for (int c = 0; c < 9; c++) begin
      ext_biu_ar_ready = rdy_tab[c];
      req_val = (c == 8) ? 2'b00 : 2'b11;
      #1;
      if (c > 0) begin
        a = ar_q[0]; total++;
        if (biu_ext_ar_valid !== 1'b1 || biu_ext_ar_id !== a.id || biu_ext_ar_addr !== a.addr) begin
          bad++; $display("FAIL bp_ar%0d: valid=%b id=%0d addr=%h want id=%0d addr=%h", c, biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, a.id, a.addr);
        end
        if (rdy_tab[c]) void'(ar_q.pop_front());
      end
      total++;
      if (req_ack !== ack_tab[c]) begin bad++; $display("FAIL bp_ack%0d: got %b want %b", c, req_ack, ack_tab[c]); end
      if (ack_tab[c] != 2'b00) push_ar(ack_tab[c][1] ? 4'd1 : 4'd0, ack_tab[c][1] ? 32'h0000_4000 : 32'h0000_3000);
      step();
    end
    #1; total++;
    if (biu_ext_ar_valid !== 1'b0) begin bad++; $display("FAIL bp_ar_idle: valid=%b want 0", biu_ext_ar_valid); end
    for (int j = 0; j < 3; j++) begin
      drive_r(1'b1, drain_id[j], 32'hB000_0000 + DW'(j), 2'b00, 1'b1, (drain_id[j] == 4'd0) ? 2'b01 : 2'b10); #1;
      e = rsp_q.pop_front(); total++;
      if (rsp_val !== e.val || rsp_err !== e.err || (e.val != '0 && rsp_data !== e.data)) begin
        bad++; $display("FAIL bp_rsp%0d: val=%b err=%b data=%h want val=%b err=%b data=%h", j, rsp_val, rsp_err, rsp_data, e.val, e.err, e.data);
      end
      step();
    end
    idle();
  endtask

  task automatic test_out_limit();
    rsp_t e;
    logic [1:0] rv_tab  [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01};
    logic [1:0] ack_tab [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
    do_reset(); ext_biu_ar_ready = 1'b1; req_addr = {32'h0000_6100, 32'h0000_6000};
    for (int c = 0; c < 7; c++) begin
      req_val = rv_tab[c];
      if (c == 4)      drive_r(1'b1, 4'd0, 32'h600D_0004, 2'b00, 1'b0, 2'b00);
      else if (c == 5) drive_r(1'b1, 4'd0, 32'h600D_0005, 2'b00, 1'b1, 2'b01);
      else             drive_r(1'b0, 4'd0, 32'h0, 2'b00, 1'b0, 2'b00);
      #1;
      total++;
      if (req_ack !== ack_tab[c]) begin bad++; $display("FAIL lim_ack%0d: got %b want %b", c, req_ack, ack_tab[c]); end
      e = rsp_q.pop_front(); total++;
      if (rsp_val !== e.val || rsp_err !== e.err || (e.val != '0 && rsp_data !== e.data)) begin
        bad++; $display("FAIL lim_rsp%0d: val=%b err=%b data=%h want val=%b", c, rsp_val, rsp_err, rsp_data, e.val);
      end
      step();
    end
    idle();
    for (int j = 0; j < 6; j++) begin
      if (j < 4)       drive_r(1'b1, 4'd0, 32'h7000_0000 + DW'(j), 2'b00, 1'b1, 2'b01);
      else if (j == 4) drive_r(1'b1, 4'd1, 32'h7100_0000, 2'b00, 1'b1, 2'b10);
      else             drive_r(1'b1, 4'd0, 32'h7200_0000, 2'b00, 1'b1, 2'b00);
      #1;
      e = rsp_q.pop_front(); total++;
      if (rsp_val !== e.val || rsp_err !== e.err || (e.val != '0 && rsp_data !== e.data)) begin
        bad++; $display("FAIL lim_drain%0d: val=%b err=%b data=%h want val=%b data=%h", j, rsp_val, rsp_err, rsp_data, e.val, e.data);
      end
      step();
    end
    idle();
  endtask

  task automatic test_cancel();
    rsp_t e;
    do_reset(); ext_biu_ar_ready = 1'b1; req_addr = {32'h0, 32'h0000_8000};
    for (int c = 0; c < 4; c++) begin
      req_val = 2'b01;
      req_cancel = (c == 3) ? 2'b01 : 2'b00;
      #1; total++;
      if (req_ack !== 2'b01) begin bad++; $display("FAIL cancel_ack%0d: got %b want 01", c, req_ack); end
      step();
    end
    idle(); step();
    for (int j = 0; j < 4; j++) begin
      drive_r(1'b1, 4'd0, 32'h5000_0000 + DW'(j), 2'b00, 1'b1, CANCEL_EN ? 2'b00 : 2'b01); #1;
      e = rsp_q.pop_front(); total++;
      if (rsp_val !== e.val || rsp_err !== e.err || (e.val != '0 && rsp_data !== e.data)) begin
        bad++; $display("FAIL cancel_rsp%0d: val=%b data=%h want val=%b data=%h", j, rsp_val, rsp_data, e.val, e.data);
      end
      step();
    end
    idle(); req_val = 2'b01; #1; total++;
    if (req_ack !== 2'b01) begin bad++; $display("FAIL cancel_ack5: got %b want 01", req_ack); end
    step(); idle(); step();
    drive_r(1'b1, 4'd0, 32'hC0FF_EE00, 2'b00, 1'b1, 2'b01); #1;
    e = rsp_q.pop_front(); total++;
    if (rsp_val !== e.val || rsp_err !== e.err || rsp_data !== e.data) begin
      bad++; $display("FAIL cancel_rsp5: val=%b data=%h want val=%b data=%h", rsp_val, rsp_data, e.val, e.data);
    end
    step(); idle();
  endtask

  task automatic test_err_stray();
    rsp_t e;
    logic [3:0] id_tab [4] = '{4'd5, 4'd1, 4'd0, 4'd0};
    logic [1:0] rs_tab [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0] ev_tab [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    do_reset(); ext_biu_ar_ready = 1'b1; req_addr = {32'h0, 32'h0000_9000};
    req_val = 2'b01; #1; total++;
    if (req_ack !== 2'b01) begin bad++; $display("FAIL err_ack: got %b want 01", req_ack); end
    step(); idle(); step();
    for (int j = 0; j < 4; j++) begin
      drive_r(1'b1, id_tab[j], 32'hBAD0_0000 + DW'(j), rs_tab[j], 1'b1, ev_tab[j]); #1;
      e = rsp_q.pop_front(); total++;
      if (rsp_val !== e.val || rsp_err !== e.err || (e.val != '0 && rsp_data !== e.data)) begin
        bad++; $display("FAIL err_rsp%0d: val=%b err=%b data=%h want val=%b err=%b data=%h", j, rsp_val, rsp_err, rsp_data, e.val, e.err, e.data);
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rsp_t e;
    do_reset(); ext_biu_ar_ready = 1'b0; req_addr = {32'h0, 32'h0000_A000};
    req_val = 2'b01; #1; total++;
    if (req_ack !== 2'b01) begin bad++; $display("FAIL rmid_ack: got %b want 01", req_ack); end
    step(); req_val = 2'b00; resetn = 1'b0;
    step(); resetn = 1'b1; #1; total++;
    if (biu_ext_ar_valid !== 1'b0 || biu_ext_ar_addr !== '0) begin
      bad++; $display("FAIL rmid_ar: valid=%b addr=%h want 0", biu_ext_ar_valid, biu_ext_ar_addr);
    end
    ext_biu_ar_ready = 1'b1;
    drive_r(1'b1, 4'd0, 32'h1111_2222, 2'b00, 1'b1, 2'b00); #1;
    e = rsp_q.pop_front(); total++;
    if (rsp_val !== e.val || rsp_err !== e.err) begin
      bad++; $display("FAIL rmid_rsp: val=%b err=%b want val=%b", rsp_val, rsp_err, e.val);
    end
    step(); idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_out_limit();
    test_cancel();
    test_err_stray();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
